// File: rtl/calc.sv
// calc: signed up/down accumulator with sign activation for a binarised neuron.
// Define CALC_SATURATE_EN to clamp at the signed bounds; otherwise acc wraps.
module calc #(
  parameter int alu_width            = 12,
  parameter int signed ACT_THRESHOLD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 calc_1,
  input  logic                 calc_in,
  output logic [alu_width-1:0] agg_out2alu,
  output logic                 agg_out_acted
);

  localparam logic [alu_width-1:0] acc_max = {1'b0, {(alu_width-1){1'b1}}};
  localparam logic [alu_width-1:0] acc_min = {1'b1, {(alu_width-1){1'b0}}};
  localparam logic [alu_width-1:0] acc_one = {{(alu_width-1){1'b0}}, 1'b1};

  logic [alu_width-1:0] acc_r;
  logic [alu_width-1:0] acc_next_s;
  logic signed [31:0]   acc_ext_s;

  // Next accumulator value for an enabled edge: +1 on agree, -1 on disagree.
  always_comb begin
    acc_next_s = acc_r;
`ifdef CALC_SATURATE_EN
    if (!calc_in) begin
      if (acc_r == acc_max) begin
        acc_next_s = acc_r;
      end else begin
        acc_next_s = acc_r + acc_one;
      end
    end else begin
      if (acc_r == acc_min) begin
        acc_next_s = acc_r;
      end else begin
        acc_next_s = acc_r - acc_one;
      end
    end
`else
    if (!calc_in) begin
      acc_next_s = acc_r + acc_one;
    end else begin
      acc_next_s = acc_r - acc_one;
    end
`endif
  end

  // Accumulator register; reset wins over accumulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r <= '0;
    end else if (calc_1) begin
      acc_r <= acc_next_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  // Sign-extend so the threshold compare is done at full integer width.
  always_comb begin
    acc_ext_s = 32'(signed'(acc_r));
  end

  assign agg_out2alu   = acc_r;
  assign agg_out_acted = (acc_ext_s >= ACT_THRESHOLD);

endmodule

// File: tb/tb_calc.sv
// tb_calc: randomized + directed scoreboard bench for calc, two configurations
// (12-bit / threshold 0 and 4-bit / threshold 3) driven by the same stimulus.
module tb_calc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        calc_1;
  logic        calc_in;
  logic [11:0] out_a;
  logic        act_a;
  logic [3:0]  out_b;
  logic        act_b;

  calc #(.alu_width(12), .ACT_THRESHOLD(0)) u_a (
    .clk(clk), .rst(rst), .calc_1(calc_1), .calc_in(calc_in),
    .agg_out2alu(out_a), .agg_out_acted(act_a)
  );

  calc #(.alu_width(4), .ACT_THRESHOLD(3)) u_b (
    .clk(clk), .rst(rst), .calc_1(calc_1), .calc_in(calc_in),
    .agg_out2alu(out_b), .agg_out_acted(act_b)
  );

  typedef struct {
    int acc_a;
    bit act_a;
    int acc_b;
    bit act_b;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_a = 0;
  int   m_b = 0;

  // Reference arithmetic: a signed w-bit register holding value v.
  function automatic int fold(input int v, input int w);
    int span;
    int r;
    span = 1 << w;
`ifdef CALC_SATURATE_EN
    if (v > span / 2 - 1) r = span / 2 - 1;
    else if (v < -(span / 2)) r = -(span / 2);
    else r = v;
`else
    r = v % span;
    if (r < 0) r = r + span;
    if (r >= span / 2) r = r - span;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of stimulus; the model result goes to the scoreboard.
  task automatic step(input bit r, input bit e, input bit d);
    exp_t x;
    @(negedge clk);
    rst     = r;
    calc_1  = e;
    calc_in = d;
    @(posedge clk);
    if (!r) begin
      m_a = 0;
      m_b = 0;
    end else if (e) begin
      m_a = fold(m_a + (d ? -1 : 1), 12);
      m_b = fold(m_b + (d ? -1 : 1), 4);
    end
    x.acc_a = m_a;
    x.act_a = (m_a >= 0);
    x.acc_b = m_b;
    x.act_b = (m_b >= 3);
    sb_q.push_back(x);
  endtask

  task automatic repeat_step(input int n, input bit e, input bit d);
    for (int i = 0; i < n; i++) step(1'b1, e, d);
  endtask

  // Enabled inputs in random order with an exact number of disagreements.
  task automatic sweep(input int n, input int m);
    int left_n;
    int left_m;
    bit d;
    left_n = n;
    left_m = m;
    while (left_n > 0) begin
      d = ($urandom_range(left_n - 1, 0) < left_m);
      if (d) left_m--;
      left_n--;
      step(1'b1, 1'b1, d);
    end
  endtask

  // Monitor: compare every registered output against the queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("acc_w12", int'($signed(out_a)), e.acc_a);
      chk("act_w12", int'(act_a), int'(e.act_a));
      chk("acc_w4",  int'($signed(out_b)), e.acc_b);
      chk("act_w4",  int'(act_b), int'(e.act_b));
    end
  end

  initial begin
    rst     = 1'b1;
    calc_1  = 1'b0;
    calc_in = 1'b0;

    // Reset then hold.
    step(1'b0, 1'b0, 1'b0);
    repeat_step(5, 1'b0, 1'b0);
    #2;
    chk("hold_zero", int'($signed(out_a)), 0);
    chk("hold_act", int'(act_a), 1);

    // Agree/disagree sum.
    step(1'b0, 1'b0, 1'b0);
    repeat_step(10, 1'b1, 1'b0);
    repeat_step(3, 1'b1, 1'b1);
    #2;
    chk("sum_seven", int'($signed(out_a)), 7);
    chk("sum_seven_act", int'(act_a), 1);
    repeat_step(8, 1'b1, 1'b1);
    #2;
    chk("sum_minus1", int'(out_a), 12'hFFF);
    chk("sum_minus1_act", int'(act_a), 0);

    // Reset priority over an enabled agree edge.
    step(1'b0, 1'b0, 1'b0);
    repeat_step(5, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    #2;
    chk("rst_prio", int'($signed(out_a)), 0);
    step(1'b1, 1'b1, 1'b0);
    #2;
    chk("rst_resume", int'($signed(out_a)), 1);

    // Threshold on the 4-bit / threshold 3 instance.
    step(1'b0, 1'b0, 1'b0);
    repeat_step(2, 1'b1, 1'b0);
    #2;
    chk("thr_two", int'(act_b), 0);
    step(1'b1, 1'b1, 1'b0);
    #2;
    chk("thr_three", int'(act_b), 1);

    // Overflow boundary on the 4-bit instance: 9 increments from zero.
    step(1'b0, 1'b0, 1'b0);
    repeat_step(9, 1'b1, 1'b0);
    #2;
`ifdef CALC_SATURATE_EN
    chk("ovf_w4", int'($signed(out_b)), 7);
`else
    chk("ovf_w4", int'(out_b), 4'h9);
`endif
    // Underflow on the 4-bit instance: from there, 20 decrements.
    repeat_step(20, 1'b1, 1'b1);

    // Neuron sweeps.
    step(1'b0, 1'b0, 1'b0);
    sweep(1024, 512);
    #2;
    chk("sweep_512", int'($signed(out_a)), 0);
    chk("sweep_512_act", int'(act_a), 1);
    step(1'b0, 1'b0, 1'b0);
    sweep(1024, 513);
    #2;
    chk("sweep_513", int'($signed(out_a)), -2);
    chk("sweep_513_act", int'(act_a), 0);

    // Random traffic including sporadic resets and long one-way runs.
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 < 40) step(1'b1, 1'b1, (i / 500) % 2 == 1);
      else step($urandom_range(63, 0) != 0, $urandom_range(3, 0) != 0,
                $urandom_range(1, 0) == 1);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc.md
CALC -- requirements
Module: calc

Interface
REQ-001 Parameter alu_width, default 12: width of the accumulator and of agg_out2alu; legal range 4..32.
REQ-002 Parameter ACT_THRESHOLD, default 0: signed threshold used by the sign activation.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low; it clears the accumulator when sampled low.
REQ-005 Port calc_1, input, 1 bit: accumulate enable; when high, calc_in is consumed on that edge.
REQ-006 Port calc_in, input, 1 bit: XOR of weight bit and activation bit; 0 means agree (XNOR = 1), 1 means disagree.
REQ-007 Port agg_out2alu, output, alu_width bits: the accumulator value, two's-complement signed.
REQ-008 Port agg_out_acted, output, 1 bit: sign activation of the accumulator.

Function
REQ-009 Accumulator acc SHALL be a signed alu_width-bit register driven directly onto agg_out2alu.
REQ-010 On an edge with rst=1, calc_1=1 and calc_in=0, acc SHALL increment by 1.
REQ-011 On an edge with rst=1, calc_1=1 and calc_in=1, acc SHALL decrement by 1.
REQ-012 On an edge with rst=1 and calc_1=0, acc SHALL hold its value.
REQ-013 agg_out_acted SHALL be combinational from acc: 1 when signed acc >= ACT_THRESHOLD, else 0.
REQ-014 Latency: an input sampled at edge N SHALL be reflected on agg_out2alu and agg_out_acted immediately after edge N (one-cycle registered latency, no extra pipeline).
REQ-015 After N enabled inputs with M disagreements, acc SHALL equal N - 2*M, absent overflow.
REQ-016 Overflow handling at the signed bounds SHALL follow REQ-023/REQ-024.
REQ-017 There is no internal state machine; the only state is acc.
REQ-018 No input combination SHALL produce X on the outputs once rst has been applied.

Reset
REQ-019 When rst is sampled low on a rising edge, acc SHALL become 0 regardless of calc_1 and calc_in; reset has priority over accumulation.
REQ-020 Output values during and after reset: agg_out2alu = 0; agg_out_acted = 1 with the default ACT_THRESHOLD = 0.
REQ-021 Reset mid-accumulation SHALL discard the partial sum in the same edge; accumulation resumes on the first edge with rst=1.
REQ-022 Before the first reset, outputs are undefined; the integrator SHALL assert rst for at least one edge before use.

Configuration
REQ-023 With macro CALC_SATURATE_EN defined, acc SHALL saturate: an increment at 2^(alu_width-1)-1 and a decrement at -2^(alu_width-1) SHALL leave acc unchanged.
REQ-024 Without CALC_SATURATE_EN, acc SHALL wrap modulo 2^alu_width: 2047+1 gives -2048 and -2048-1 gives 2047 for alu_width=12.

Verification
REQ-025 Reset then hold: rst=0 for 1 edge, then rst=1 and calc_1=0 for 5 edges -> agg_out2alu=0 and agg_out_acted=1 throughout.
REQ-026 Agree/disagree sum: after reset, apply 10 enabled edges with calc_in=0, then 3 with calc_in=1 -> agg_out2alu=7 and agg_out_acted=1; apply 8 more with calc_in=1 -> agg_out2alu=-1 (0xFFF) and agg_out_acted=0.
REQ-027 Reset priority: after acc=5, drive rst=0, calc_1=1 and calc_in=0 on one edge -> agg_out2alu=0 after that edge; the next enabled calc_in=0 edge gives 1.
REQ-028 Neuron sweep: 1024 enabled inputs with 512 disagreements -> acc=0 and agg_out_acted=1; repeat after reset with 513 disagreements -> acc=-2 and agg_out_acted=0.
REQ-029 Overflow boundary: with alu_width=4, apply 9 enabled calc_in=0 edges -> acc=7 with CALC_SATURATE_EN defined, acc=-7 (0x9) without it.
REQ-030 Threshold: with ACT_THRESHOLD=3, acc=2 -> agg_out_acted=0 and acc=3 -> agg_out_acted=1.
